// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : N-channel push-button front end. Each channel is synchronised,
//            debounced and turned into a stable level plus one-cycle
//            press/release pulses. The optional auto-repeat pulse generator
//            is built only when BTN_REPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_REPEAT_EN
    localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);
    localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
    localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [0:0] {
        PH_DELAY    = 1'b0,
        PH_PERIODIC = 1'b1
    } phase_t;
`else
    logic w_unused_repeat_cfg;
    assign w_unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic              r_s1;
        logic              r_s2;
        logic              r_level;
        logic              r_press;
        logic              r_release;
        logic [c_DB_W-1:0] r_db_cnt;
        logic              w_flip;

        // The level flips on the cycle the counter has seen a full window of disagreement.
        assign w_flip = (r_s2 != r_level) && (r_db_cnt == c_DB_LAST);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_db_cnt  <= '0;
            end else begin
                r_s1      <= btn_raw[i];
                r_s2      <= r_s1;
                r_press   <= w_flip &&  r_s2;
                r_release <= w_flip && !r_s2;
                if (r_s2 == r_level) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == c_DB_LAST) begin
                    r_level  <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;

`ifdef BTN_REPEAT_EN
        phase_t             r_phase;
        phase_t             w_phase_next;
        logic [c_REP_W-1:0] r_rep_cnt;
        logic [c_REP_W-1:0] w_rep_cnt_next;
        logic               r_repeat;
        logic               w_repeat_next;
        logic               w_rep_hit;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_phase   <= PH_DELAY;
                r_rep_cnt <= '0;
                r_repeat  <= 1'b0;
            end else begin
                r_phase   <= w_phase_next;
                r_rep_cnt <= w_rep_cnt_next;
                r_repeat  <= w_repeat_next;
            end
        end

        // A level flip (press or release) restarts the delay phase and
        // suppresses any repeat pulse that would land on the same edge.
        always_comb begin
            w_phase_next   = r_phase;
            w_rep_cnt_next = r_rep_cnt;
            w_repeat_next  = 1'b0;
            w_rep_hit      = (r_phase == PH_PERIODIC) ? (r_rep_cnt == c_PERIOD_LAST)
                                                      : (r_rep_cnt == c_DELAY_LAST);
            if (w_flip) begin
                w_phase_next   = PH_DELAY;
                w_rep_cnt_next = '0;
            end else if (r_level) begin
                if (w_rep_hit) begin
                    w_repeat_next  = 1'b1;
                    w_rep_cnt_next = '0;
                    w_phase_next   = PH_PERIODIC;
                end else begin
                    w_rep_cnt_next = r_rep_cnt + c_REP_W'(1);
                end
            end
        end

        assign btn_repeat[i] = r_repeat;
`else
        assign btn_repeat[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed stimulus with a queue of hand-computed expected output
//            events, checked by an independent monitor on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int c_N      = 5;
    localparam int c_DB     = 4;
    localparam int c_DELAY  = 10;
    localparam int c_PERIOD = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [c_N-1:0] btn_raw = '0;
    logic [c_N-1:0] btn_level;
    logic [c_N-1:0] btn_press;
    logic [c_N-1:0] btn_release;
    logic [c_N-1:0] btn_repeat;

    button_conditioner #(
        .N_BTN          (c_N),
        .DEBOUNCE_CYCLES(c_DB),
        .REPEAT_DELAY   (c_DELAY),
        .REPEAT_PERIOD  (c_PERIOD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [c_N-1:0] lvl;
        logic [c_N-1:0] pr;
        logic [c_N-1:0] rl;
        logic [c_N-1:0] rp;
    } ev_t;

    ev_t            q[$];
    int             cyc = 0;
    int             checks = 0;
    int             failures = 0;
    bit             mon_on = 1'b0;
    logic [c_N-1:0] exp_lvl = '0;
    logic [c_N-1:0] cur_lvl = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [c_N-1:0] act, input logic [c_N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    // Monitor: consumes the expected event due this cycle, flags anything unexpected.
    always @(negedge clk) begin
        if (mon_on) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event cycle=%0d actual=none required_at=%0d", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("press",   btn_press,   q[0].pr);
                chk("release", btn_release, q[0].rl);
                chk("repeat",  btn_repeat,  q[0].rp);
                exp_lvl = q[0].lvl;
                void'(q.pop_front());
            end else if (|{btn_press, btn_release, btn_repeat}) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse cycle=%0d actual=%b/%b/%b required=00000/00000/00000",
                         cyc, btn_press, btn_release, btn_repeat);
            end
            chk("level", btn_level, exp_lvl);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [c_N-1:0] lvl, input logic [c_N-1:0] pr,
                        input logic [c_N-1:0] rl, input logic [c_N-1:0] rp);
        ev_t e;
        e.cyc = c; e.lvl = lvl; e.pr = pr; e.rl = rl; e.rp = rp;
        q.push_back(e);
    endtask

    // Repeats at P+DELAY, then every PERIOD, strictly before the release edge R.
    task automatic push_repeats(input logic [c_N-1:0] mask, input int p, input int r,
                                input logic [c_N-1:0] lvl);
`ifdef BTN_REPEAT_EN
        for (int k = p + c_DELAY; k < r; k += c_PERIOD)
            push(k, lvl, '0, '0, mask);
`endif
    endtask

    // Raw key held for `hold` cycles: press at edge 6, release 6 edges after the fall.
    task automatic hold_key(input logic [c_N-1:0] mask, input int hold, input int gap);
        int t0;
        t0 = cyc;
        push(t0 + c_DB + 2, cur_lvl | mask, mask, '0, '0);
        push_repeats(mask, t0 + c_DB + 2, t0 + hold + c_DB + 2, cur_lvl | mask);
        push(t0 + hold + c_DB + 2, cur_lvl, '0, mask, '0);
        btn_raw = btn_raw | mask;
        step(hold);
        btn_raw = btn_raw & ~mask;
        step(gap);
    endtask

    initial begin
        int t0;
        push(1, '0, '0, '0, '0);
        step(1);
        mon_on = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);

        // Clean press on channel 0, held 30 cycles
        hold_key(5'b00001, 30, 12);

        // Glitch shorter than the debounce window, then a minimum-length hold
        btn_raw[2] = 1'b1;
        step(3);
        btn_raw[2] = 1'b0;
        step(10);
        hold_key(5'b00100, 4, 12);

        // Long hold on channel 4; a repeat due on the release edge is suppressed
        hold_key(5'b10000, 25, 12);

        // Two channels rising together
        hold_key(5'b01010, 8, 12);

        // Input toggling faster than the debounce window
        for (int k = 0; k < 10; k++) begin
            btn_raw[3] = ~btn_raw[3];
            step(2);
        end
        btn_raw[3] = 1'b0;
        step(10);

        // Reset while channel 0 is held: no release, fresh press after reset
        t0 = cyc;
        btn_raw[0] = 1'b1;
        push(t0 + 6, 5'b00001, 5'b00001, '0, '0);
        step(10);
        push(t0 + 11, '0, '0, '0, '0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        push(t0 + 18, 5'b00001, 5'b00001, '0, '0);
        push_repeats(5'b00001, t0 + 18, t0 + 36, 5'b00001);
        push(t0 + 36, '0, '0, 5'b00001, '0);
        step(18);
        btn_raw[0] = 1'b0;
        step(15);

        mon_on = 1'b0;
        while (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL pending_event actual=none required_at=%0d", q[0].cyc);
            void'(q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
